mips_fetch_decode_exec: RTL and testbench
=========================================

Name: mips_fetch_decode_exec

Overview:
- Multi-cycle front end of the MIPS core: instruction fetch, decode/control/register read, and ALU execute.
- Sequences one instruction at a time and signals when the execute result is valid.
- Downstream memory/writeBack stages write the register file through a write port, then return a done token to start the next fetch.

Parameters:
- PC_WIDTH, 4, PC and instruction-memory address width (16 words).
- DATA_WIDTH, 32, instruction/register/ALU width.

Ports:
- clock  in  1  system clock, rising edge.
- start  in  1  asynchronous active-high reset.
- imem_we  in  1  instruction memory write enable (bench/loader).
- imem_addr  in  4  instruction memory write address.
- imem_wdata  in  32  instruction memory write data.
- wb_done  in  1  writeback finished; advance to next instruction.
- wb_en  in  1  register file write enable.
- wb_addr  in  5  register file write address.
- wb_data  in  32  register file write data.
- pc  out  4  current program counter (word index).
- instruction  out  32  latched instruction.
- opcode 6 / rs 5 / rt 5 / rd 5 / shamt 5 / funct 6  out  decoded fields.
- immediate  out  32  sign-extended instr[15:0].
- reg_dest, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, end_program  out  1 each  control signals.
- alu_op  out  2  ALU operation class.
- read_data1, read_data2  out  32  register file reads of rs, rt.
- alu_out  out  32  ALU result.
- zero  out  1  alu_out == 0.
- exec_valid  out  1  one-cycle pulse: execute result valid.

Behaviour:
- Reset (start=1, async): state=FETCH; pc=0; all outputs 0; register file cleared to 0; imem contents kept. Reset mid-instruction aborts and restarts at pc 0.
- imem write is synchronous, allowed in any state. Register write (wb_en) is synchronous, allowed in any state. Writes to $0 are ignored; reads of $0 return 0.
- States: FETCH -> DECODE -> EXEC -> WAIT -> FETCH, plus HALT.
- FETCH edge: instruction <= imem[pc].
- DECODE edge: register all fields, immediate, controls, read_data1/2.
- EXEC edge: register alu_out and zero; exec_valid=1 for exactly the following cycle.
- WAIT: hold all outputs. On an edge with wb_done=1: pc <= branch&&zero ? pc+1+immediate[3:0] : pc+1 (mod 16); go to FETCH.
- If end_program=1 at the DECODE edge, go to HALT instead of EXEC. HALT ignores wb_done, freezes pc, and is left only by reset.
- First exec_valid appears after the 3rd rising edge following reset release.
- Control decode (all other controls 0):
  - 000000 R-type: reg_dest, reg_write, alu_op=10.
  - 100011 lw: alu_src, mem_read, mem_to_reg, reg_write, alu_op=00.
  - 101011 sw: alu_src, mem_write, alu_op=00.
  - 000100 beq: branch, alu_op=01.
  - 001000 addi: alu_src, reg_write, alu_op=00.
  - 111111 halt: end_program.
  - Any other opcode: all controls 0 (nop).
- ALU: operand B = alu_src ? immediate : read_data2.
  - alu_op 00: add. 01: sub. 11: add.
  - alu_op 10 by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 signed slt (1/0), 000000 sll (B << shamt); other funct -> 0.
  - Arithmetic is 32-bit, wrap-around, no overflow flag.

Test Plan:
- Reset, imem[0]=0x20010005 (addi $1,$0,5) -> after edge 3: rt=1, immediate=5, alu_src=1, reg_write=1, alu_out=5, zero=0, exec_valid=1 for one cycle; pc stays 0 until wb_done, then pc=1.
- Preload $1=5, $2=7 via wb port; 0x00221822 (sub $3,$1,$2) -> alu_out=0xFFFFFFFE, reg_dest=1. 0x0022182A (slt) -> alu_out=1. 0x00221824 (and) -> alu_out=5.
- $1=$2=5; beq at pc=3, 0x10220002 -> zero=1, branch=1; after wb_done pc=6. Same instruction at pc=15 with offset 0 -> pc wraps to 0. Not-taken case ($2=7) -> pc=4.
- $2=0x100; 0x8C41FFFC (lw $1,-4($2)) -> immediate=0xFFFFFFFC, alu_out=0xFC, mem_read=1, mem_to_reg=1. wb_en with wb_addr=0, data=9 -> read of $0 stays 0.
- 0xFC000000 (halt) -> end_program=1, exec_valid never pulses, pc frozen despite wb_done pulses; assert start -> pc=0, state FETCH.
- Assert start during DECODE -> all outputs 0 immediately; after release, the instruction at pc 0 is re-executed.

Source files
------------

// File: rtl/mips_fetch_decode_exec_if.sv
// mips_fetch_decode_exec_if: loader, writeback and observation bundle of the MIPS front end
interface mips_fetch_decode_exec_if #(
  parameter int PC_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic imem_we;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic wb_done;
  logic wb_en;
  logic [4:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [PC_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] instruction;
  logic [5:0] opcode;
  logic [4:0] rs, rt, rd, shamt;
  logic [5:0] funct;
  logic [DATA_WIDTH-1:0] immediate;
  logic reg_dest, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, end_program;
  logic [1:0] alu_op;
  logic [DATA_WIDTH-1:0] read_data1, read_data2, alu_out;
  logic zero, exec_valid;
  modport master (
    output imem_we, imem_addr, imem_wdata, wb_done, wb_en, wb_addr, wb_data,
    input pc, instruction, opcode, rs, rt, rd, shamt, funct, immediate, reg_dest, branch,
    mem_read, mem_to_reg, mem_write, alu_src, reg_write, end_program, alu_op,
    read_data1, read_data2, alu_out, zero, exec_valid
  );
  modport slave (
    input imem_we, imem_addr, imem_wdata, wb_done, wb_en, wb_addr, wb_data,
    output pc, instruction, opcode, rs, rt, rd, shamt, funct, immediate, reg_dest, branch,
    mem_read, mem_to_reg, mem_write, alu_src, reg_write, end_program, alu_op,
    read_data1, read_data2, alu_out, zero, exec_valid
  );
endinterface

// File: rtl/mips_fetch_decode_exec.sv
// mips_fetch_decode_exec: multi-cycle MIPS fetch, decode/register read and ALU execute front end
module mips_fetch_decode_exec #(
  parameter int PC_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic clock,
  input logic start,
  mips_fetch_decode_exec_if.slave bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WAIT, HALT} state_t;
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs, rt, rd, shamt;
    logic [5:0] funct;
    logic [DATA_WIDTH-1:0] immediate;
    logic reg_dest, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, end_program;
    logic [1:0] alu_op;
    logic [DATA_WIDTH-1:0] read_data1, read_data2;
  } dec_t;
  state_t state_q, state_d;
  dec_t dec_q, dec_d, dec_n;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instruction_q, instruction_d, alu_out_q, alu_out_d;
  logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_r;
  logic zero_q, zero_d, exec_valid_q, exec_valid_d;
  logic [DATA_WIDTH-1:0] imem [2**PC_WIDTH];
  logic [DATA_WIDTH-1:0] regs_q [32];
  always_comb begin
    dec_n = '0;
    {dec_n.opcode, dec_n.rs, dec_n.rt, dec_n.rd, dec_n.shamt, dec_n.funct} = instruction_q[31:0];
    dec_n.immediate = {{(DATA_WIDTH-16){instruction_q[15]}}, instruction_q[15:0]};
    dec_n.read_data1 = regs_q[instruction_q[25:21]];
    dec_n.read_data2 = regs_q[instruction_q[20:16]];
    case (instruction_q[31:26])
      6'b000000: {dec_n.reg_dest, dec_n.reg_write, dec_n.alu_op} = 4'b1110;
      6'b100011: {dec_n.alu_src, dec_n.mem_read, dec_n.mem_to_reg, dec_n.reg_write} = 4'b1111;
      6'b101011: {dec_n.alu_src, dec_n.mem_write} = 2'b11;
      6'b000100: {dec_n.branch, dec_n.alu_op} = 3'b101;
      6'b001000: {dec_n.alu_src, dec_n.reg_write} = 2'b11;
      6'b111111: dec_n.end_program = 1'b1;
      default: ;
    endcase
  end
  assign alu_a = dec_q.read_data1;
  assign alu_b = dec_q.alu_src ? dec_q.immediate : dec_q.read_data2;
  always_comb begin
    alu_r = alu_a + alu_b;
    if (dec_q.alu_op == 2'b01) alu_r = alu_a - alu_b;
    else if (dec_q.alu_op == 2'b10)
      case (dec_q.funct)
        6'b100000: alu_r = alu_a + alu_b;
        6'b100010: alu_r = alu_a - alu_b;
        6'b100100: alu_r = alu_a & alu_b;
        6'b100101: alu_r = alu_a | alu_b;
        6'b100111: alu_r = ~(alu_a | alu_b);
        6'b101010: alu_r = DATA_WIDTH'($signed(alu_a) < $signed(alu_b));
        6'b000000: alu_r = alu_b << dec_q.shamt;
        default: alu_r = '0;
      endcase
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instruction_d = instruction_q;
    dec_d = dec_q;
    alu_out_d = alu_out_q;
    zero_d = zero_q;
    exec_valid_d = 1'b0;
    case (state_q)
      FETCH: begin
        instruction_d = imem[pc_q];
        state_d = DECODE;
      end
      DECODE: begin
        dec_d = dec_n;
        state_d = dec_n.end_program ? HALT : EXEC;
      end
      EXEC: begin
        alu_out_d = alu_r;
        zero_d = alu_r == '0;
        exec_valid_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (bus.wb_done) begin
        pc_d = pc_q + PC_WIDTH'(1) + ((dec_q.branch && zero_q) ? dec_q.immediate[PC_WIDTH-1:0] : '0);
        state_d = FETCH;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clock or posedge start)
    if (start) begin
      state_q <= FETCH;
      pc_q <= '0;
      instruction_q <= '0;
      dec_q <= '0;
      alu_out_q <= '0;
      zero_q <= 1'b0;
      exec_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instruction_q <= instruction_d;
      dec_q <= dec_d;
      alu_out_q <= alu_out_d;
      zero_q <= zero_d;
      exec_valid_q <= exec_valid_d;
    end
  // $0 is never written, so its reset value doubles as the hardwired zero
  always_ff @(posedge clock or posedge start)
    if (start) for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    else if (bus.wb_en && bus.wb_addr != 5'd0) regs_q[bus.wb_addr] <= bus.wb_data;
  always_ff @(posedge clock)
    if (bus.imem_we) imem[bus.imem_addr] <= bus.imem_wdata;
  assign bus.pc = pc_q;
  assign bus.instruction = instruction_q;
  assign bus.opcode = dec_q.opcode;
  assign bus.rs = dec_q.rs;
  assign bus.rt = dec_q.rt;
  assign bus.rd = dec_q.rd;
  assign bus.shamt = dec_q.shamt;
  assign bus.funct = dec_q.funct;
  assign bus.immediate = dec_q.immediate;
  assign bus.reg_dest = dec_q.reg_dest;
  assign bus.branch = dec_q.branch;
  assign bus.mem_read = dec_q.mem_read;
  assign bus.mem_to_reg = dec_q.mem_to_reg;
  assign bus.mem_write = dec_q.mem_write;
  assign bus.alu_src = dec_q.alu_src;
  assign bus.reg_write = dec_q.reg_write;
  assign bus.end_program = dec_q.end_program;
  assign bus.alu_op = dec_q.alu_op;
  assign bus.read_data1 = dec_q.read_data1;
  assign bus.read_data2 = dec_q.read_data2;
  assign bus.alu_out = alu_out_q;
  assign bus.zero = zero_q;
  assign bus.exec_valid = exec_valid_q;
endmodule

// File: tb/tb_mips_fetch_decode_exec.sv
// tb_mips_fetch_decode_exec: directed plus random instruction stream against an instruction-level model
module tb_mips_fetch_decode_exec;
  logic clk = 1'b0;
  logic start = 1'b0;
  int passed = 0, fails = 0, total = 0;
  logic [31:0] mregs [32];
  logic [31:0] mimem [16];
  logic [3:0] mpc, m_imm4;
  logic [31:0] m_ins, m_alu;
  logic [9:0] m_ctrl;
  logic m_taken;
  mips_fetch_decode_exec_if bus ();
  mips_fetch_decode_exec dut (.clock(clk), .start(start), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  // {reg_dest, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, end_program, alu_op}
  function automatic logic [9:0] ctrl(input logic [5:0] op);
    case (op)
      6'h00: return 10'b1000001010;
      6'h23: return 10'b0011011000;
      6'h2b: return 10'b0000110000;
      6'h04: return 10'b0100000001;
      6'h08: return 10'b0000011000;
      6'h3f: return 10'b0000000100;
      default: return 10'b0;
    endcase
  endfunction
  function automatic logic [31:0] ref_alu(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    logic [31:0] imm;
    imm = {{16{ins[15]}}, ins[15:0]};
    case (ins[31:26])
      6'h00:
        case (ins[5:0])
          6'h20: return r1 + r2;
          6'h22: return r1 - r2;
          6'h24: return r1 & r2;
          6'h25: return r1 | r2;
          6'h27: return ~(r1 | r2);
          6'h2a: return ($signed(r1) < $signed(r2)) ? 32'd1 : 32'd0;
          6'h00: return r2 << ins[10:6];
          default: return 32'd0;
        endcase
      6'h23, 6'h2b, 6'h08: return r1 + imm;
      6'h04: return r1 - r2;
      default: return r1 + r2;
    endcase
  endfunction
  function automatic logic [31:0] gen();
    logic [5:0] ops [6];
    logic [5:0] fns [8];
    logic [31:0] r;
    logic [5:0] op;
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h0c};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00, 6'h03};
    r = $urandom;
    op = ops[$urandom_range(0, 5)];
    r[25:21] = 5'($urandom_range(0, 3));
    r[20:16] = 5'($urandom_range(0, 3));
    if (op == 6'h00) r[5:0] = fns[$urandom_range(0, 7)];
    return {op, r[25:0]};
  endfunction
  task automatic load0(input logic [31:0] ins);
    bus.imem_we = 1'b1;
    bus.imem_addr = 4'd0;
    bus.imem_wdata = ins;
    mimem[0] = ins;
    step;
    bus.imem_we = 1'b0;
  endtask
  task automatic wreg(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
    if (a != 5'd0) mregs[a] = d;
    step;
    bus.wb_en = 1'b0;
  endtask
  task automatic zero_check(input string tag);
    chk({tag, "_pc"}, 32'(bus.pc), 32'd0);
    chk({tag, "_instr"}, bus.instruction, 32'd0);
    chk({tag, "_ctrl"}, 32'({bus.reg_dest, bus.branch, bus.mem_read, bus.mem_to_reg, bus.mem_write,
        bus.alu_src, bus.reg_write, bus.end_program, bus.alu_op}), 32'd0);
    chk({tag, "_data"}, bus.read_data1 | bus.read_data2 | bus.alu_out | bus.immediate, 32'd0);
    chk({tag, "_flags"}, 32'({bus.zero, bus.exec_valid}), 32'd0);
  endtask
  task automatic model_reset;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mpc = 4'd0;
  endtask
  task automatic run_instr(input logic [31:0] ins);
    logic [31:0] r1, r2, imm;
    r1 = mregs[ins[25:21]];
    r2 = mregs[ins[20:16]];
    imm = {{16{ins[15]}}, ins[15:0]};
    m_ins = ins;
    m_ctrl = ctrl(ins[31:26]);
    m_alu = ref_alu(ins, r1, r2);
    m_taken = ins[31:26] == 6'h04 && r1 == r2;
    m_imm4 = ins[3:0];
    step;
    chk("fetch_instr", bus.instruction, ins);
    step;
    chk("fields", {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct}, ins);
    chk("immediate", bus.immediate, imm);
    chk("ctrl", 32'({bus.reg_dest, bus.branch, bus.mem_read, bus.mem_to_reg, bus.mem_write,
        bus.alu_src, bus.reg_write, bus.end_program, bus.alu_op}), 32'(m_ctrl));
    chk("read_data1", bus.read_data1, r1);
    chk("read_data2", bus.read_data2, r2);
    if (m_ctrl[2]) return;
    chk("valid_pre", 32'(bus.exec_valid), 32'd0);
    step;
    chk("alu_out", bus.alu_out, m_alu);
    chk("zero", 32'(bus.zero), 32'(m_alu == 32'd0));
    chk("exec_valid", 32'(bus.exec_valid), 32'd1);
    step;
    chk("valid_drop", 32'(bus.exec_valid), 32'd0);
    chk("pc_hold", 32'(bus.pc), 32'(mpc));
  endtask
  task automatic go(input logic [31:0] nxt);
    logic [3:0] npc;
    logic [4:0] dest;
    logic [31:0] wd;
    npc = mpc + 4'd1 + (m_taken ? m_imm4 : 4'd0);
    bus.imem_we = 1'b1;
    bus.imem_addr = npc;
    bus.imem_wdata = nxt;
    mimem[npc] = nxt;
    bus.wb_done = 1'b1;
    if (m_ctrl[3]) begin
      dest = m_ctrl[9] ? m_ins[15:11] : m_ins[20:16];
      wd = m_ctrl[6] ? $urandom : m_alu;
      bus.wb_en = 1'b1;
      bus.wb_addr = dest;
      bus.wb_data = wd;
      if (dest != 5'd0) mregs[dest] = wd;
    end
    step;
    bus.imem_we = 1'b0;
    bus.wb_done = 1'b0;
    bus.wb_en = 1'b0;
    chk("pc_next", 32'(bus.pc), 32'(npc));
    mpc = npc;
  endtask
  initial begin
    logic [31:0] ins;
    bus.imem_we = 1'b0;
    bus.imem_addr = '0;
    bus.imem_wdata = '0;
    bus.wb_done = 1'b0;
    bus.wb_en = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    model_reset;
    m_ctrl = '0;
    m_taken = 1'b0;
    start = 1'b1;
    @(negedge clk);
    load0(32'h20010005);
    zero_check("reset");
    start = 1'b0;
    run_instr(32'h20010005);
    wreg(5'd2, 32'd7);
    go(32'h00221822);
    run_instr(32'h00221822);
    go(32'h00221824);
    run_instr(32'h00221824);
    wreg(5'd2, 32'd5);
    go(32'h10220002);
    run_instr(32'h10220002);
    chk("beq_pc", 32'(mpc), 32'd3);
    wreg(5'd2, 32'd7);
    go(32'h0022182A);
    chk("beq_taken_pc", 32'(bus.pc), 32'd6);
    run_instr(32'h0022182A);
    go(32'h10220002);
    run_instr(32'h10220002);
    go(32'h10000006);
    chk("beq_not_taken_pc", 32'(bus.pc), 32'd8);
    run_instr(32'h10000006);
    wreg(5'd2, 32'd5);
    go(32'h10220000);
    chk("pc15", 32'(bus.pc), 32'd15);
    run_instr(32'h10220000);
    wreg(5'd2, 32'h100);
    go(32'h8C41FFFC);
    chk("pc_wrap", 32'(bus.pc), 32'd0);
    run_instr(32'h8C41FFFC);
    wreg(5'd0, 32'd9);
    go(32'h20040000);
    run_instr(32'h20040000);
    for (int k = 0; k < 24; k++) begin
      ins = gen();
      go(ins);
      run_instr(ins);
    end
    go(32'hFC000000);
    run_instr(32'hFC000000);
    for (int k = 0; k < 3; k++) begin
      bus.wb_done = 1'b1;
      step;
      chk("halt_valid", 32'(bus.exec_valid), 32'd0);
      chk("halt_pc", 32'(bus.pc), 32'(mpc));
      chk("halt_end", 32'(bus.end_program), 32'd1);
    end
    bus.wb_done = 1'b0;
    start = 1'b1;
    #1;
    zero_check("halt_reset");
    @(negedge clk);
    start = 1'b0;
    model_reset;
    step;
    chk("refetch", bus.instruction, mimem[0]);
    start = 1'b1;
    #1;
    zero_check("decode_reset");
    @(negedge clk);
    start = 1'b0;
    model_reset;
    run_instr(mimem[0]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
